// File: rtl/round_referee_if.sv
// Round referee handshake bundle: round request, LFSR bit, player presses in;
// busy/go and verdict flags out. The LFSR bit is carried as rand_bit ("rand" is reserved).
interface round_referee_if;
  logic start;
  logic rand_bit;
  logic btn_l;
  logic btn_r;
  logic busy;
  logic go;
  logic win_l;
  logic win_r;
  logic tie;
  logic timeout;
  logic false_l;
  logic false_r;

  modport master (
    output start, rand_bit, btn_l, btn_r,
    input  busy, go, win_l, win_r, tie, timeout, false_l, false_r
  );

  modport slave (
    input  start, rand_bit, btn_l, btn_r,
    output busy, go, win_l, win_r, tie, timeout, false_l, false_r
  );
endinterface

// File: rtl/round_referee.sv
// Tug-of-war round referee: randomized start delay from the LFSR stream, first-press judging,
// verdict hold. Optional early-press penalty enabled by ROUND_REFEREE_FALSE_START_EN.
module round_referee #(
  parameter int unsigned SEED_BITS  = 6,
  parameter int unsigned MIN_WAIT   = 500,
  parameter int unsigned GO_TIMEOUT = 2000,
  parameter int unsigned HOLD       = 1000,
  parameter int unsigned CNT_W      = 16
) (
  input logic            clk,
  input logic            rst,
  round_referee_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SEED, WAIT, GO, DONE} state_t;

  // Verdict vector layout: {win_l, win_r, tie, timeout, false_l, false_r}
  localparam logic [5:0] V_WIN_L   = 6'b100000;
  localparam logic [5:0] V_WIN_R   = 6'b010000;
  localparam logic [5:0] V_TIE     = 6'b001000;
  localparam logic [5:0] V_TIMEOUT = 6'b000100;
`ifdef ROUND_REFEREE_FALSE_START_EN
  localparam logic [5:0] V_FALSE_L = 6'b000010;
  localparam logic [5:0] V_FALSE_R = 6'b000001;
`endif

  localparam logic [CNT_W-1:0] SEED_LAST  = CNT_W'(SEED_BITS - 1);
  localparam logic [CNT_W-1:0] MIN_WAIT_C = CNT_W'(MIN_WAIT);
  localparam logic [CNT_W-1:0] GO_LAST    = CNT_W'(GO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [SEED_BITS-1:0] delay, delay_nxt, delay_shift;
  logic                 busy_q, busy_nxt;
  logic                 go_q, go_nxt;
  logic [5:0]           flags_q, flags_nxt;
  logic [5:0]           press_flags;
  logic                 press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      delay   <= '0;
      busy_q  <= 1'b0;
      go_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      delay   <= delay_nxt;
      busy_q  <= busy_nxt;
      go_q    <= go_nxt;
      flags_q <= flags_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    delay_nxt   = delay;
    busy_nxt    = busy_q;
    go_nxt      = 1'b0;
    flags_nxt   = flags_q;
    press       = bus.btn_l | bus.btn_r;
    delay_shift = {delay[SEED_BITS-2:0], bus.rand_bit};

    if (bus.btn_l && bus.btn_r) press_flags = V_TIE;
    else if (bus.btn_l)         press_flags = V_WIN_L;
    else                        press_flags = V_WIN_R;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = SEED;
          flags_nxt = '0;
          delay_nxt = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
        end
      end
      SEED: begin
        // cnt doubles as the sample counter; the wait load uses the shift value including this sample
        delay_nxt = delay_shift;
        if (cnt == SEED_LAST) begin
          cnt_nxt   = MIN_WAIT_C + CNT_W'(delay_shift);
          state_nxt = WAIT;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = GO;
          go_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      GO: begin
        go_nxt  = 1'b1;
        cnt_nxt = cnt + CNT_ONE;
        if (press) begin
          flags_nxt = press_flags;
          go_nxt    = 1'b0;
          cnt_nxt   = HOLD_LAST;
          state_nxt = DONE;
        end else if (cnt == GO_LAST) begin
          flags_nxt = V_TIMEOUT;
          go_nxt    = 1'b0;
          cnt_nxt   = HOLD_LAST;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase

`ifdef ROUND_REFEREE_FALSE_START_EN
    // Early press overrides the seed/wait progress and forfeits the round to the other player
    if ((state == SEED || state == WAIT) && press) begin
      if (bus.btn_l && bus.btn_r) flags_nxt = V_FALSE_L | V_FALSE_R;
      else if (bus.btn_l)         flags_nxt = V_FALSE_L | V_WIN_R;
      else                        flags_nxt = V_FALSE_R | V_WIN_L;
      go_nxt    = 1'b0;
      cnt_nxt   = HOLD_LAST;
      state_nxt = DONE;
    end
`endif
  end

  assign bus.busy    = busy_q;
  assign bus.go      = go_q;
  assign bus.win_l   = flags_q[5];
  assign bus.win_r   = flags_q[4];
  assign bus.tie     = flags_q[3];
  assign bus.timeout = flags_q[2];

`ifdef ROUND_REFEREE_FALSE_START_EN
  assign bus.false_l = flags_q[1];
  assign bus.false_r = flags_q[0];
`else
  logic unused_false;
  assign unused_false = ^flags_q[1:0];
  assign bus.false_l  = 1'b0;
  assign bus.false_r  = 1'b0;
`endif

endmodule

// File: tb/tb_round_referee.sv
// Directed bench for round_referee: delay timing, winner/tie/timeout verdicts, early press,
// async reset and ignored starts; verdicts go through an expected-value queue.
module tb_round_referee;
  localparam int unsigned SB = 4;
  localparam int unsigned MW = 3;
  localparam int unsigned GT = 5;
  localparam int unsigned HD = 6;

  localparam logic [5:0] V_NONE  = 6'b000000;
  localparam logic [5:0] V_WIN_L = 6'b100000;
  localparam logic [5:0] V_WIN_R = 6'b010000;
  localparam logic [5:0] V_TIE   = 6'b001000;
  localparam logic [5:0] V_TO    = 6'b000100;
`ifdef ROUND_REFEREE_FALSE_START_EN
  localparam logic [5:0] V_FL    = 6'b000010;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  round_referee_if bus();

  round_referee #(
    .SEED_BITS(SB),
    .MIN_WAIT(MW),
    .GO_TIMEOUT(GT),
    .HOLD(HD),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ed      = 0;
  logic [5:0] sb_q[$];

  function automatic logic [5:0] flags();
    return {bus.win_l, bus.win_r, bus.tie, bus.timeout, bus.false_l, bus.false_r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ed++;
  endtask

  task automatic run_to(input int e);
    while (ed < e) tick();
  endtask

  task automatic sb_check(input string tag);
    logic [5:0] e;
    e = (sb_q.size() != 0) ? sb_q.pop_front() : 6'bxxxxxx;
    chk(tag, 32'(flags()), 32'(e));
  endtask

  task automatic start_round(input logic [SB-1:0] bits, output int n);
    bus.start = 1'b1;
    tick();
    n = ed;
    bus.start = 1'b0;
    chk("start_busy", 32'(bus.busy), 32'd1);
    chk("start_clears_flags", 32'(flags()), 32'(V_NONE));
    for (int i = SB - 1; i >= 0; i--) begin
      bus.rand_bit = bits[i];
      tick();
    end
    bus.rand_bit = 1'b0;
  endtask

  task automatic check_go_edge(input string tag, input int e);
    run_to(e - 1);
    chk({tag, "_before"}, 32'(bus.go), 32'd0);
    tick();
    chk(tag, 32'(bus.go), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (bus.busy && k < 200) begin
      tick();
      k++;
    end
    chk(tag, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n;
    int hi;
    int seen;
    logic [SB-1:0] bits;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.rand_bit = 1'b0;
    bus.btn_l    = 1'b0;
    bus.btn_r    = 1'b0;
    tick();
    tick();
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_go", 32'(bus.go), 32'd0);
    chk("reset_flags", 32'(flags()), 32'(V_NONE));
    rst = 1'b0;

    // Round 1: start at edge 10, samples 1,0,1,1 -> D=11, go at edge 29
    run_to(9);
    start_round(4'b1011, n);
    check_go_edge("r1_go_rise", 29);
    tick();
    bus.btn_r = 1'b1;
    sb_q.push_back(V_WIN_R);
    tick();
    bus.btn_r = 1'b0;
    chk("r1_go_fall", 32'(bus.go), 32'd0);
    sb_check("r1_verdict");
    run_to(32);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("r1_start_in_done", 32'(flags()), 32'(V_WIN_R));
    run_to(36);
    chk("r1_busy_hold", 32'(bus.busy), 32'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("r1_busy_fall_start_ignored", 32'(bus.busy), 32'd0);
    tick();
    chk("r1_idle_stays", 32'(bus.busy), 32'd0);
    chk("r1_sticky", 32'(flags()), 32'(V_WIN_R));

    // Round 2: D=0, simultaneous presses
    start_round(4'b0000, n);
    check_go_edge("r2_go_rise", n + SB + MW + 1);
    bus.btn_l = 1'b1;
    bus.btn_r = 1'b1;
    sb_q.push_back(V_TIE);
    tick();
    bus.btn_l = 1'b0;
    bus.btn_r = 1'b0;
    chk("r2_go_fall", 32'(bus.go), 32'd0);
    sb_check("r2_tie");
    wait_idle("r2_idle");

    // Round 3: random delay, no press -> timeout
    bits = SB'($urandom_range(0, (1 << SB) - 1));
    sb_q.push_back(V_TO);
    start_round(bits, n);
    check_go_edge("r3_go_rise", n + SB + MW + int'(bits) + 1);
    hi = 1;
    while (bus.go && hi < 50) begin
      tick();
      if (bus.go) hi++;
    end
    chk("r3_go_cycles", 32'(hi), 32'(GT));
    sb_check("r3_timeout");
    wait_idle("r3_idle");

    // Round 4: btn_l while waiting (D=15)
    start_round(4'b1111, n);
    tick();
    bus.btn_l = 1'b1;
    tick();
    bus.btn_l = 1'b0;
`ifdef ROUND_REFEREE_FALSE_START_EN
    sb_q.push_back(V_WIN_R | V_FL);
    sb_check("r4_false_start");
    seen = 0;
    while (ed < n + SB + MW + 15 + 2) begin
      tick();
      if (bus.go) seen = 1;
    end
    chk("r4_no_go", 32'(seen), 32'd0);
    wait_idle("r4_idle");
`else
    sb_q.push_back(V_NONE);
    sb_check("r4_press_ignored");
    check_go_edge("r4_go_nominal", n + SB + MW + 15 + 1);
    bus.btn_l = 1'b1;
    sb_q.push_back(V_WIN_L);
    tick();
    bus.btn_l = 1'b0;
    sb_check("r4_win_l");
    wait_idle("r4_idle");
`endif

    // Round 5: asynchronous reset mid-WAIT, then a fresh round
    start_round(4'b0100, n);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("r5_rst_busy", 32'(bus.busy), 32'd0);
    chk("r5_rst_go", 32'(bus.go), 32'd0);
    chk("r5_rst_flags", 32'(flags()), 32'(V_NONE));
    tick();
    rst = 1'b0;
    tick();
    chk("r5_idle_after_rst", 32'(bus.busy), 32'd0);
    start_round(4'b0010, n);
    check_go_edge("r5_go_rise", n + SB + MW + 2 + 1);
    bus.btn_r = 1'b1;
    sb_q.push_back(V_WIN_R);
    tick();
    bus.btn_r = 1'b0;
    sb_check("r5_win_r");
    wait_idle("r5_idle");
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
